// File: rtl/seletor_display.sv
// Registered source selector for the multi-digit 7-segment display.
// Cycles/loads among N_SRC sources, blinks the edit digit, and falls back to source 0 when idle.
module seletor_display #(
  parameter int N_SRC      = 4,
  parameter int DIGITS     = 8,
  parameter int SEG        = 7,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000,
  parameter int TIMEOUT_HP = 20,
  localparam int W_SRC     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int W_DIG     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_SRC*DIGITS*SEG-1:0]   fontes,
  input  logic                          seletor_prox,
  input  logic                          seletor_dir,
  input  logic [W_SRC-1:0]              seletor_idx,
  input  logic                          editar,
  input  logic [W_DIG-1:0]              digito_edit,
  output logic [DIGITS*SEG-1:0]         saida,
  output logic [W_SRC-1:0]              fonte_atual,
  output logic                          piscando
);

  localparam int W_BLK = $clog2(BLINK_DIV);
  localparam int W_TO  = (TIMEOUT_HP > 0) ? $clog2(TIMEOUT_HP + 1) : 1;
  localparam logic [W_BLK-1:0] BLK_LAST = W_BLK'(BLINK_DIV - 1);
  localparam logic [W_TO-1:0]  TO_LAST  = W_TO'(TIMEOUT_HP);
  localparam logic [W_SRC-1:0] SRC_LAST = W_SRC'(N_SRC - 1);
  localparam logic [SEG-1:0]   BLANK    = {SEG{ACTIVE_LOW != 0}};

  logic [W_BLK-1:0] blk_cnt, blk_nxt, cnt_eff;
  logic [W_TO-1:0]  to_cnt, to_nxt;
  logic [W_SRC-1:0] fonte_nxt;
  logic [DIGITS*SEG-1:0] frame_nxt;
  logic editar_q, editar_rise, wrap, idx_ok, expire, restart, pisc_nxt;

  always_comb begin
    editar_rise = editar & ~editar_q;
    cnt_eff     = editar_rise ? '0 : blk_cnt;
    wrap        = (cnt_eff == BLK_LAST);
    idx_ok      = (32'(seletor_idx) < 32'(N_SRC));
    expire      = (TIMEOUT_HP != 0) && (to_cnt == TO_LAST) && (fonte_atual != '0);
    // Idle timebase restarts on any activity so the fallback delay is measured from it.
    restart     = seletor_prox | seletor_dir | (fonte_atual == '0);

    fonte_nxt = fonte_atual;
    if (seletor_dir) begin
      if (idx_ok) fonte_nxt = seletor_idx;
    end else if (seletor_prox) begin
      fonte_nxt = (fonte_atual == SRC_LAST) ? '0 : fonte_atual + 1'b1;
    end else if (expire) begin
      fonte_nxt = '0;
    end

    if (editar)       blk_nxt = wrap ? '0 : cnt_eff + 1'b1;
    else if (restart) blk_nxt = '0;
    else              blk_nxt = wrap ? '0 : blk_cnt + 1'b1;

    pisc_nxt = editar ? (piscando ^ wrap) : 1'b0;

    to_nxt = to_cnt;
    if (restart || editar || expire || TIMEOUT_HP == 0) to_nxt = '0;
    else if (wrap && to_cnt != TO_LAST)                 to_nxt = to_cnt + 1'b1;

    frame_nxt = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (editar && piscando && int'(digito_edit) == d)
        frame_nxt[d*SEG +: SEG] = BLANK;
      else
        frame_nxt[d*SEG +: SEG] = fontes[(int'(fonte_atual)*DIGITS + d)*SEG +: SEG];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fonte_atual <= '0;
      piscando    <= 1'b0;
      blk_cnt     <= '0;
      to_cnt      <= '0;
      editar_q    <= 1'b0;
      saida       <= {DIGITS{BLANK}};
    end else begin
      fonte_atual <= fonte_nxt;
      piscando    <= pisc_nxt;
      blk_cnt     <= blk_nxt;
      to_cnt      <= to_nxt;
      editar_q    <= editar;
      saida       <= frame_nxt;
    end
  end

endmodule
